// File: rtl/uart_pwm_frame_if.sv
// ---------------------------------------------------------------------------
// uart_pwm_frame_if
// Purpose : bundles the received-byte stream and the frame status pulses of
//           uart_pwm_frame so a byte source and a frame observer can be
//           connected as one unit.
// Signals : rx_valid  - one-cycle strobe, one received byte per strobe
//           rx_data   - received byte, meaningful only while rx_valid=1
//           frame_ok  - one-cycle pulse, frame accepted
//           frame_err - one-cycle pulse, frame dropped
// Handshake: strobe-only stream with no back-pressure. The consumer samples
//           rx_valid on every rising clock edge and must take every byte it
//           sees; a producer may strobe on consecutive cycles.
// Modports: master - byte source (drives rx_*, observes status)
//           slave  - frame parser (consumes rx_*, drives status)
// ---------------------------------------------------------------------------
interface uart_pwm_frame_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       frame_ok;
  logic       frame_err;

  modport master (
    output rx_valid,
    output rx_data,
    input  frame_ok,
    input  frame_err
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    output frame_ok,
    output frame_err
  );
endinterface

// File: rtl/uart_pwm_frame.sv
// ---------------------------------------------------------------------------
// uart_pwm_frame
// Purpose : parses fixed-length UART frames (NUM_CH data bytes followed by a
//           0x0A terminator) into per-channel PWM duty bytes and drives
//           NUM_CH PWM outputs from one shared period counter. New duties
//           are committed only at the period boundary.
// Optional: define UART_PWM_TIMEOUT_EN to enable the inter-byte gap timeout
//           that drops a stalled partial frame after TIMEOUT_CYC idle cycles.
// Ports   : i_clk        - clock, rising edge
//           i_resetn     - asynchronous active-low reset
//           i_rx_valid   - one-cycle strobe per received byte (no ready;
//                          every strobe is consumed, back-to-back allowed)
//           i_rx_data    - received byte, valid while i_rx_valid=1
//           i_pwm_en     - 0 forces o_pwm low, counter keeps running
//           o_pwm        - registered PWM outputs, bit k from frame byte k
//           o_frame_ok   - one-cycle pulse, frame accepted
//           o_frame_err  - one-cycle pulse, frame dropped
//           o_err_cnt    - saturating dropped-frame count
//           o_duty0      - active duty byte of channel 0
//           o_dbg_state  - parser state (0=DATA, 1=TERM, 2=RESYNC)
// ---------------------------------------------------------------------------
module uart_pwm_frame #(
  parameter int NUM_CH      = 2,
  parameter int PWM_PERIOD  = 540540,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  input  logic              i_pwm_en,
  output logic [NUM_CH-1:0] o_pwm,
  output logic              o_frame_ok,
  output logic              o_frame_err,
  output logic [7:0]        o_err_cnt,
  output logic [7:0]        o_duty0,
  output logic [1:0]        o_dbg_state
);

  // Counter width is the minimum that holds PWM_PERIOD-1.
  localparam int              CW        = $clog2(PWM_PERIOD);
  localparam int              IW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CW-1:0]   CNT_LAST  = CW'(PWM_PERIOD - 1);
  localparam logic [IW-1:0]   IDX_LAST  = IW'(NUM_CH - 1);
  localparam logic [CW+7:0]   PERIOD_W  = (CW + 8)'(PWM_PERIOD);
  localparam logic [7:0]      TERM_BYTE = 8'h0A;

  if (NUM_CH < 1 || NUM_CH > 16 || PWM_PERIOD < 2 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("uart_pwm_frame: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_DATA   = 2'd0,
    ST_TERM   = 2'd1,
    ST_RESYNC = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    pend_q, pend_d;
  logic [NUM_CH-1:0][7:0]  rx_buf_q, rx_buf_d;
  logic [NUM_CH-1:0][7:0]  pend_buf_q, pend_buf_d;
  logic [NUM_CH-1:0][7:0]  duty_q, duty_d;
  logic [NUM_CH-1:0]       pwm_q, pwm_d;
  logic                    ok_q, ok_d;
  logic                    err_q, err_d;
  logic [7:0]              err_cnt_q, err_cnt_d;
  logic [NUM_CH-1:0][CW-1:0] thr;
  logic                    wrap;
  logic                    timeout_hit;

  assign wrap  = (cnt_q == CNT_LAST);
  assign cnt_d = wrap ? '0 : cnt_q + CW'(1);

`ifdef UART_PWM_TIMEOUT_EN
  localparam int             GW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [GW-1:0]  GAP_MAX = GW'(TIMEOUT_CYC);

  logic [GW-1:0] gap_q, gap_d;
  logic          gap_active;

  // Only a partially received frame is timed; an idle line between frames
  // (DATA with idx=0) or a resync hunt never times out.
  assign gap_active  = ((state_q == ST_DATA) && (idx_q != '0)) || (state_q == ST_TERM);
  // A byte arriving in the expiry cycle takes priority over the timeout.
  assign timeout_hit = gap_active && (gap_q == GAP_MAX) && !i_rx_valid;

  always_comb begin
    gap_d = gap_q;
    if (i_rx_valid || timeout_hit) begin
      gap_d = '0;
    end else if (gap_active) begin
      gap_d = gap_q + GW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end
`else
  // Without the timeout a partial frame waits indefinitely.
  assign timeout_hit = 1'b0;
`endif

  // Parser, pending-frame and duty commit logic.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rx_buf_d   = rx_buf_q;
    pend_buf_d = pend_buf_q;
    pend_d     = pend_q;
    duty_d     = duty_q;
    ok_d       = 1'b0;
    err_d      = 1'b0;
    err_cnt_d  = err_cnt_q;

    // Commit at the boundary uses the pending buffer as it stands this
    // cycle; a frame accepted in the same cycle overrides pend_d below and
    // therefore waits for the next boundary.
    if (wrap && pend_q) begin
      duty_d = pend_buf_q;
      pend_d = 1'b0;
    end

    if (i_rx_valid) begin
      case (state_q)
        ST_DATA: begin
          // Framing is positional: 0x0A in a data slot is ordinary data.
          rx_buf_d[idx_q] = i_rx_data;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = ST_TERM;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        ST_TERM: begin
          if (i_rx_data == TERM_BYTE) begin
            pend_buf_d = rx_buf_q;
            pend_d     = 1'b1;
            ok_d       = 1'b1;
            state_d    = ST_DATA;
          end else begin
            err_d   = 1'b1;
            state_d = ST_RESYNC;
          end
        end
        ST_RESYNC: begin
          if (i_rx_data == TERM_BYTE) begin
            state_d = ST_DATA;
            idx_d   = '0;
          end
        end
        default: begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      endcase
    end else if (timeout_hit) begin
      err_d   = 1'b1;
      state_d = ST_DATA;
      idx_d   = '0;
    end

    if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Threshold per channel: (duty * PWM_PERIOD) >> 8, computed at full
  // product width so nothing is lost before the shift.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign thr[k]   = CW'(((CW + 8)'(duty_q[k]) * PERIOD_W) >> 8);
    assign pwm_d[k] = (cnt_q < thr[k]) & i_pwm_en;
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q    <= ST_DATA;
      idx_q      <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      rx_buf_q   <= '0;
      pend_buf_q <= '0;
      duty_q     <= '0;
      pwm_q      <= '0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      rx_buf_q   <= rx_buf_d;
      pend_buf_q <= pend_buf_d;
      duty_q     <= duty_d;
      pwm_q      <= pwm_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign o_pwm       = pwm_q;
  assign o_frame_ok  = ok_q;
  assign o_frame_err = err_q;
  assign o_err_cnt   = err_cnt_q;
  assign o_duty0     = duty_q[0];
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_uart_pwm_frame.sv
// ---------------------------------------------------------------------------
// tb_uart_pwm_frame
// Directed bench for uart_pwm_frame with NUM_CH=2, PWM_PERIOD=256,
// TIMEOUT_CYC=100. With a 256-cycle period the threshold equals the duty
// byte, so the high-cycle count per period equals the frame byte.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_pwm_frame;
  localparam int NUM_CH      = 2;
  localparam int PWM_PERIOD  = 256;
  localparam int TIMEOUT_CYC = 100;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              pwm_en = 1'b0;
  logic [NUM_CH-1:0] pwm;
  logic [7:0]        err_cnt;
  logic [7:0]        duty0;
  logic [1:0]        dbg_state;
  logic [7:0]        tcnt;      // bench model of the period counter

  always #5 clk = ~clk;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) tcnt <= 8'd0;
    else         tcnt <= tcnt + 8'd1;
  end

  uart_pwm_frame_if rx_if();

  uart_pwm_frame #(
    .NUM_CH      (NUM_CH),
    .PWM_PERIOD  (PWM_PERIOD),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .i_clk       (clk),
    .i_resetn    (resetn),
    .i_rx_valid  (rx_if.rx_valid),
    .i_rx_data   (rx_if.rx_data),
    .i_pwm_en    (pwm_en),
    .o_pwm       (pwm),
    .o_frame_ok  (rx_if.frame_ok),
    .o_frame_err (rx_if.frame_err),
    .o_err_cnt   (err_cnt),
    .o_duty0     (duty0),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_q[$];     // {byte1, byte0} of frames expected to go active
  logic [7:0]  exp_err = 8'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rx_if.frame_ok === 1'b1 && rx_if.frame_err === 1'b1) begin
      miscompares++;
      $error("FAIL ok_err_overlap: observed ok=1 err=1 expected not both");
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, output logic ok, output logic err);
    @(negedge clk);
    rx_if.rx_valid = 1'b1;
    rx_if.rx_data  = b;
    @(negedge clk);
    rx_if.rx_valid = 1'b0;
    rx_if.rx_data  = 8'h00;
    ok  = rx_if.frame_ok;
    err = rx_if.frame_err;
  endtask

  task automatic send_quiet(input string tag, input logic [7:0] b);
    logic ok, err;
    send_byte(b, ok, err);
    check({tag, "_ok"}, ok, 1'b0);
    check({tag, "_err"}, err, 1'b0);
  endtask

  task automatic send_good(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                           input bit push);
    logic ok, err;
    send_byte(b0, ok, err);
    send_byte(b1, ok, err);
    send_byte(8'h0A, ok, err);
    check({tag, "_ok"}, ok, 1'b1);
    check({tag, "_err"}, err, 1'b0);
    if (push) exp_q.push_back({b1, b0});
  endtask

  task automatic wait_tcnt(input logic [7:0] v);
    int guard = 0;
    while (tcnt != v && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 600) begin
      miscompares++;
      $error("FAIL wait_tcnt: observed timeout expected tcnt=%0d", v);
    end
  endtask

  // Skip past two period boundaries so any pending frame is active, then
  // count high cycles over one full period.
  task automatic measure(output int c0, output int c1);
    int seen = 0;
    int guard = 0;
    c0 = 0;
    c1 = 0;
    while (seen < 2 && guard < 1000) begin
      @(negedge clk);
      guard++;
      if (tcnt == 8'd1) seen++;
    end
    if (seen < 2) begin
      miscompares++;
      $error("FAIL measure_sync: observed %0d boundaries expected 2", seen);
    end
    repeat (PWM_PERIOD) begin
      @(negedge clk);
      c0 += int'(pwm[0]);
      c1 += int'(pwm[1]);
    end
  endtask

  task automatic check_duty(input string tag);
    int c0, c1;
    logic [15:0] e;
    measure(c0, c1);
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s_queue: observed empty expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_hi0"}, c0, {24'd0, e[7:0]});
      check({tag, "_hi1"}, c1, {24'd0, e[15:8]});
      check({tag, "_duty0"}, duty0, e[7:0]);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic ok, err;
    int c0, c1;
    int first_k;
    int n_err;

    rx_if.rx_valid = 1'b0;
    rx_if.rx_data  = 8'h00;
    pwm_en = 1'b1;
    resetn = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_pwm", pwm, 2'b00);
    check("rst_ok", rx_if.frame_ok, 1'b0);
    check("rst_err", rx_if.frame_err, 1'b0);
    check("rst_errcnt", err_cnt, 8'd0);
    check("rst_duty0", duty0, 8'd0);
    check("rst_state", dbg_state, 2'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("rel_pwm", pwm, 2'b00);
    check("rel_ok", rx_if.frame_ok, 1'b0);

    // Duty 0 is constant low
    measure(c0, c1);
    check("zero_hi0", c0, 0);
    check("zero_hi1", c1, 0);

    // Basic frame 0x40,0x80 -> 64/256 and 128/256
    send_good("f4080", 8'h40, 8'h80, 1'b1);
    check_duty("f4080");

    // Enable low forces outputs low while duty stays
    pwm_en = 1'b0;
    measure(c0, c1);
    check("en0_hi0", c0, 0);
    check("en0_hi1", c1, 0);
    check("en0_duty0", duty0, 8'h40);
    pwm_en = 1'b1;

    // Bad terminator, resync, then good frame 0x30,0x30
    send_quiet("bad_b0", 8'h10);
    send_quiet("bad_b1", 8'h20);
    send_byte(8'h55, ok, err);
    exp_err++;
    check("bad_term_ok", ok, 1'b0);
    check("bad_term_err", err, 1'b1);
    check("bad_errcnt", err_cnt, exp_err);
    check("bad_state", dbg_state, 2'd2);
    send_quiet("resync_0a", 8'h0A);
    check("resync_state", dbg_state, 2'd0);
    check("resync_errcnt", err_cnt, exp_err);
    send_good("f3030", 8'h30, 8'h30, 1'b1);
    check_duty("f3030");

    // 0x0A in data slots is data
    send_good("f0a0a", 8'h0A, 8'h0A, 1'b1);
    check_duty("f0a0a");

    // Back-to-back strobes 0x80,0x01,0x0A
    @(negedge clk);
    rx_if.rx_valid = 1'b1;
    rx_if.rx_data  = 8'h80;
    @(negedge clk);
    rx_if.rx_data  = 8'h01;
    @(negedge clk);
    rx_if.rx_data  = 8'h0A;
    @(negedge clk);
    rx_if.rx_valid = 1'b0;
    rx_if.rx_data  = 8'h00;
    check("b2b_ok", rx_if.frame_ok, 1'b1);
    exp_q.push_back(16'h0180);
    check_duty("b2b");

`ifdef UART_PWM_TIMEOUT_EN
    // Stall after byte 0: error exactly 101 cycles after the byte edge
    send_quiet("to_b0", 8'h40);
    first_k = 0;
    n_err = 0;
    for (int k = 1; k <= 150; k++) begin
      @(negedge clk);
      if (rx_if.frame_err === 1'b1) begin
        n_err++;
        if (first_k == 0) first_k = k;
      end
    end
    exp_err++;
    check("to_first", first_k, 101);
    check("to_count", n_err, 1);
    check("to_errcnt", err_cnt, exp_err);
    check("to_state", dbg_state, 2'd0);
    send_quiet("to_c0", 8'hC0);
    send_quiet("to_ff", 8'hFF);
    send_byte(8'h0A, ok, err);
    check("to_acc_ok", ok, 1'b1);
    exp_q.push_back(16'hFFC0);
    check_duty("to_cff");
`else
    // Without timeout the partial frame waits; 0xC0 completes it, 0xFF fails
    send_quiet("nt_b0", 8'h40);
    n_err = 0;
    for (int k = 1; k <= 150; k++) begin
      @(negedge clk);
      if (rx_if.frame_err === 1'b1) n_err++;
    end
    check("nt_idle_err", n_err, 0);
    send_quiet("nt_c0", 8'hC0);
    send_byte(8'hFF, ok, err);
    exp_err++;
    check("nt_ff_err", err, 1'b1);
    check("nt_errcnt", err_cnt, exp_err);
    send_quiet("nt_0a", 8'h0A);
    send_good("nt_cff", 8'hC0, 8'hFF, 1'b1);
    check_duty("nt_cff");
`endif

    // Latest pending frame wins
    wait_tcnt(8'd10);
    send_good("lw_a", 8'h01, 8'h02, 1'b0);
    send_good("lw_b", 8'h05, 8'h06, 1'b1);
    check_duty("lw");

    // Accept at cnt=255 while pending: old frame commits, new one next period
    wait_tcnt(8'd100);
    send_good("wr_a", 8'h11, 8'h22, 1'b0);
    send_quiet("wr_b0", 8'h33);
    send_quiet("wr_b1", 8'h44);
    wait_tcnt(8'd254);
    send_byte(8'h0A, ok, err);
    check("wr_b_ok", ok, 1'b1);
    check("wr_first_duty0", duty0, 8'h11);
    @(negedge clk);
    wait_tcnt(8'd0);
    check("wr_second_duty0", duty0, 8'h33);
    exp_q.push_back(16'h4433);
    check_duty("wr");

    // Reset mid-frame
    send_quiet("mr_b0", 8'h20);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    exp_err = 8'd0;
    check("mr_pwm", pwm, 2'b00);
    check("mr_duty0", duty0, 8'd0);
    check("mr_errcnt", err_cnt, 8'd0);
    check("mr_ok", rx_if.frame_ok, 1'b0);
    check("mr_err", rx_if.frame_err, 1'b0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    send_good("mr_f", 8'h20, 8'h20, 1'b1);
    check_duty("mr_f");

    // Error counter saturation
    for (int i = 0; i < 255; i++) begin
      send_byte(8'h01, ok, err);
      send_byte(8'h02, ok, err);
      send_byte(8'h03, ok, err);
      send_byte(8'h0A, ok, err);
    end
    check("sat_255", err_cnt, 8'd255);
    send_byte(8'h01, ok, err);
    send_byte(8'h02, ok, err);
    send_byte(8'h03, ok, err);
    check("sat_err_pulse", err, 1'b1);
    check("sat_hold", err_cnt, 8'd255);
    send_quiet("sat_0a", 8'h0A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_pwm_frame.md
UART_PWM_FRAME -- requirements
Module: uart_pwm_frame

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2: number of PWM channels, which is also the number of data bytes per frame (1..16).
REQ-002 The block SHALL have parameter PWM_PERIOD, default 540540: PWM period in clock cycles (at least 2).
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 1000000: maximum number of idle cycles allowed between bytes inside a frame.
REQ-004 The block SHALL have port i_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port i_resetn, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port i_rx_valid, input, 1 bit: one-cycle strobe marking a received UART byte.
REQ-007 The block SHALL have port i_rx_data, input, 8 bits: the received byte, valid only when i_rx_valid=1.
REQ-008 The block SHALL have port i_pwm_en, input, 1 bit: 0 forces all PWM outputs low; the period counter keeps running.
REQ-009 The block SHALL have port o_pwm, output, NUM_CH bits: PWM outputs, where bit k is driven by frame byte k.
REQ-010 The block SHALL have port o_frame_ok, output, 1 bit: one-cycle pulse when a frame is accepted.
REQ-011 The block SHALL have port o_frame_err, output, 1 bit: one-cycle pulse when a frame is dropped.
REQ-012 The block SHALL have port o_err_cnt, output, 8 bits: saturating count of dropped frames.
REQ-013 The block SHALL have port o_duty0, output, 8 bits: active duty byte of channel 0, for status LEDs.

Function
REQ-014 The parser SHALL have three states: DATA, TERM and RESYNC; a byte index idx counts 0..NUM_CH-1.
REQ-015 In DATA, each i_rx_valid SHALL store i_rx_data into rx_buf[idx]; at idx=NUM_CH-1 it SHALL go to TERM and clear idx.
  - Framing is by position only; 0x0A in a data slot is legal data.
REQ-016 In TERM, a byte of 0x0A SHALL copy rx_buf to pend_buf, set pend, pulse o_frame_ok in the next cycle and return to DATA.
REQ-017 In TERM, any other byte SHALL pulse o_frame_err, increment o_err_cnt and go to RESYNC.
REQ-018 In RESYNC, bytes SHALL be discarded until 0x0A arrives, which returns the parser to DATA with idx=0 and produces no ok/err pulse.
REQ-019 o_err_cnt SHALL saturate at 255 and never wrap.
REQ-020 The period counter cnt SHALL run 0..PWM_PERIOD-1 and wrap to 0; its width is the minimum needed for PWM_PERIOD-1.
REQ-021 In the cycle cnt=PWM_PERIOD-1 with pend=1, duty SHALL be loaded from pend_buf and pend cleared.
  - Duty is only updated at the period boundary, so no PWM glitches.
REQ-022 Simultaneous wrap and frame accept: the wrap SHALL commit the old pend_buf, and the new frame SHALL remain pending for the next wrap.
REQ-023 A second good frame arriving while pend=1 SHALL overwrite pend_buf, so the latest frame wins.
REQ-024 Each channel SHALL have threshold thr_k = (duty[k] * PWM_PERIOD) >> 8.
  - Product width: 8 plus the counter width, with no truncation before the shift.
REQ-025 o_pwm[k] SHALL be registered and equal (cnt < thr_k) AND i_pwm_en, i.e. one cycle after cnt.
  - duty 0 gives constant low.
REQ-026 o_frame_ok and o_frame_err SHALL never be asserted in the same cycle.
REQ-027 i_rx_valid SHALL be sampled every cycle; back-to-back valid strobes SHALL each be consumed.

Reset
REQ-028 On i_resetn=0, asynchronously: state=DATA, idx=0, cnt=0, pend=0, rx_buf/pend_buf/duty=0, o_pwm=0, o_frame_ok=0, o_frame_err=0, o_err_cnt=0, o_duty0=0.
REQ-029 Reset in mid-frame SHALL discard partial data; after release, the next byte is treated as byte 0.
REQ-030 Reset release SHALL be synchronous to i_clk.
  - No output toggles in the first cycle after release except cnt advancing.

Configuration
REQ-031 With UART_PWM_TIMEOUT_EN defined, a gap counter SHALL clear on each i_rx_valid and count while in DATA with idx>0, or in TERM.
REQ-032 With UART_PWM_TIMEOUT_EN defined, when the gap counter reaches TIMEOUT_CYC the block SHALL pulse o_frame_err, increment o_err_cnt and go to DATA with idx=0.
  - It goes to DATA, not RESYNC.
  - A valid byte in the same cycle wins: no timeout occurs and the byte is processed.
REQ-033 Without UART_PWM_TIMEOUT_EN, the gap counter SHALL be absent and partial frames SHALL wait indefinitely.

Verification
(NUM_CH=2, PWM_PERIOD=256, TIMEOUT_CYC=100, macro defined)
REQ-034 Bytes 0x40,0x80,0x0A -> o_frame_ok pulse; after the next wrap, o_pwm[0] high 64/256 cycles, o_pwm[1] high 128/256 cycles, o_duty0=0x40.
REQ-035 Bytes 0x10,0x20,0x55,0x0A, then 0x30,0x30,0x0A -> one o_frame_err and o_err_cnt=1; first frame discarded, then both channels 48/256.
REQ-036 Byte 0x0A,0x0A,0x0A as a frame -> accepted; both duties 0x0A; position framing confirmed.
REQ-037 0x40, then 150 idle cycles, then 0xC0,0xFF,0x0A -> timeout err at gap 100; new frame is 0xC0,0xFF with no terminator yet; next 0x0A accepts it.
REQ-038 Frame accepted exactly at cnt=255 while pend=1 -> old pend committed; new values appear one period later.
REQ-039 Reset pulse between byte 1 and byte 2 -> all outputs 0; frame 0x20,0x20,0x0A then gives 32/256 on both channels.
